// File: rtl/key_debounce_pkg.sv
// Shared state encoding and counter sizing helpers for the key debouncer.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_REPEATING = 2'd2
    } ch_state_e;

    // Bits needed to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce counter and press/repeat FSM.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DB_CYCLES     = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    input  logic repeat_en,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int DB_W  = cnt_width(DB_CYCLES);
    localparam int RPT_W = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    ch_state_e        state_q, state_d;
    logic             accept;

    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;
        db_cnt_d  = db_cnt_q;
        level_d   = level_q;
        rpt_cnt_d = rpt_cnt_q;
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        accept    = 1'b0;

        // Synchronized sample is active-low; compare against the active-high level.
        if (~sync2_q == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q >= DB_LAST) begin
            db_cnt_d = '0;
            level_d  = ~level_q;
            accept   = 1'b1;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end

        case (state_q)
            ST_RELEASED: begin
                rpt_cnt_d = '0;
                if (accept && level_d) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (accept) begin
                    state_d   = ST_RELEASED;
                    release_d = 1'b1;
                    rpt_cnt_d = '0;
                end else if (!repeat_en) begin
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q < RD_LAST) begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end else begin
                    state_d   = ST_REPEATING;
                    press_d   = 1'b1;
                    rpt_cnt_d = '0;
                end
            end
            ST_REPEATING: begin
                // Release wins over a coincident repeat tick so the pulses never overlap.
                if (accept) begin
                    state_d   = ST_RELEASED;
                    release_d = 1'b1;
                    rpt_cnt_d = '0;
                end else if (!repeat_en) begin
                    state_d   = ST_PRESSED;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q < RP_LAST) begin
                    rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                end else begin
                    press_d   = 1'b1;
                    rpt_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_RELEASED;
                rpt_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            db_cnt_q  <= '0;
            rpt_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            state_q   <= ST_RELEASED;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_cnt_q  <= db_cnt_d;
            rpt_cnt_q <= rpt_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            state_q   <= state_d;
        end
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer with auto-repeat; one independent channel per key.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS        = 3,
    parameter int DB_CYCLES     = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] KEY,
    input  logic              repeat_en,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .key_n        (KEY[g]),
            .repeat_en    (repeat_en),
            .key_level    (key_level[g]),
            .press_pulse  (press_pulse[g]),
            .release_pulse(release_pulse[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short debounce/repeat parameters.
module tb_key_debounce;

    logic       clk;
    logic       rst_n;
    logic [2:0] KEY;
    logic       repeat_en;
    logic [2:0] key_level;
    logic [2:0] press_pulse;
    logic [2:0] release_pulse;

    int errors = 0;
    int checks = 0;

    key_debounce #(
        .N_KEYS       (3),
        .DB_CYCLES    (4),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .KEY          (KEY),
        .repeat_en    (repeat_en),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish, got errors=%0d", errors);
        $fatal(1, "timeout");
    end

    // Advance n rising edges, leaving time 1 ns past the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; KEY = 3'b111; repeat_en = 1'b0;
        step(3);
        checks++; if (key_level !== 3'b000) begin errors++; $display("FAIL reset_level: got %b want 000", key_level); end
        checks++; if (press_pulse !== 3'b000) begin errors++; $display("FAIL reset_press: got %b want 000", press_pulse); end
        checks++; if (release_pulse !== 3'b000) begin errors++; $display("FAIL reset_release: got %b want 000", release_pulse); end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_clean_press();
        KEY[1] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            if (k == 5) begin
                checks++; if (key_level !== 3'b000) begin errors++; $display("FAIL press_early: level %b want 000", key_level); end
            end
            if (k == 6) begin
                checks++; if (key_level !== 3'b010) begin errors++; $display("FAIL press_level: got %b want 010", key_level); end
                checks++; if (press_pulse !== 3'b010) begin errors++; $display("FAIL press_pulse: got %b want 010", press_pulse); end
                checks++; if (release_pulse !== 3'b000) begin errors++; $display("FAIL press_norel: got %b want 000", release_pulse); end
            end
            if (k == 7) begin
                checks++; if (press_pulse !== 3'b000) begin errors++; $display("FAIL press_one_cycle: got %b want 000", press_pulse); end
            end
        end
    endtask

    task automatic test_release(input int ch);
        logic [2:0] bit_m;
        bit_m = 3'b001 << ch;
        KEY[ch] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            if (k == 5) begin
                checks++; if (key_level[ch] !== 1'b1) begin errors++; $display("FAIL release_early ch%0d: level %b want 1", ch, key_level[ch]); end
            end
            if (k == 6) begin
                checks++; if (release_pulse !== bit_m) begin errors++; $display("FAIL release_pulse ch%0d: got %b want %b", ch, release_pulse, bit_m); end
                checks++; if (key_level[ch] !== 1'b0) begin errors++; $display("FAIL release_level ch%0d: got %b want 0", ch, key_level[ch]); end
                checks++; if (press_pulse[ch] !== 1'b0) begin errors++; $display("FAIL release_nopress ch%0d: got %b want 0", ch, press_pulse[ch]); end
            end
            if (k == 7) begin
                checks++; if (release_pulse !== 3'b000) begin errors++; $display("FAIL release_one_cycle ch%0d: got %b want 000", ch, release_pulse); end
            end
        end
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        KEY[0] = 1'b0;
        step(3);
        KEY[0] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (press_pulse[0] !== 1'b0 || key_level[0] !== 1'b0) bad++;
            step(1);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL glitch: %0d cycles with level/pulse set, want 0", bad); end
    endtask

    task automatic test_bounce();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            KEY[2] = (i % 2 == 0) ? 1'b0 : 1'b1;
            for (int j = 0; j < 2; j++) begin
                step(1);
                if (press_pulse[2] === 1'b1) pulses++;
            end
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL bounce_during: got %0d pulses want 0", pulses); end
        KEY[2] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (press_pulse[2] === 1'b1) pulses++;
            if (k == 6) begin
                checks++; if (press_pulse[2] !== 1'b1) begin errors++; $display("FAIL bounce_settle: got %b want 1", press_pulse[2]); end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL bounce_count: got %0d pulses want 1", pulses); end
        test_release(2);
    endtask

    task automatic test_auto_repeat();
        logic exp;
        repeat_en = 1'b1;
        KEY[1] = 1'b0;
        step(6);
        checks++; if (press_pulse[1] !== 1'b1) begin errors++; $display("FAIL repeat_first: got %b want 1", press_pulse[1]); end
        for (int c = 1; c <= 59; c++) begin
            step(1);
            exp = (c == 20 || c == 28 || c == 36 || c == 44 || c == 52);
            checks++; if (press_pulse[1] !== exp) begin errors++; $display("FAIL repeat_c%0d: got %b want %b", c, press_pulse[1], exp); end
        end
        // Release begins; the debounce window still sees the +60 repeat tick.
        KEY[1] = 1'b1;
        for (int c = 60; c <= 66; c++) begin
            step(1);
            if (c == 60) begin
                checks++; if (press_pulse[1] !== 1'b1) begin errors++; $display("FAIL repeat_in_release: got %b want 1", press_pulse[1]); end
            end
            if (c == 65) begin
                checks++; if (release_pulse[1] !== 1'b1) begin errors++; $display("FAIL repeat_release: got %b want 1", release_pulse[1]); end
                checks++; if (press_pulse[1] !== 1'b0) begin errors++; $display("FAIL repeat_exclusive: got %b want 0", press_pulse[1]); end
                checks++; if (key_level[1] !== 1'b0) begin errors++; $display("FAIL repeat_rel_level: got %b want 0", key_level[1]); end
            end
        end
        repeat_en = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        KEY[0] = 1'b0;
        step(6);
        checks++; if (key_level !== 3'b001) begin errors++; $display("FAIL hold_pre: got %b want 001", key_level); end
        rst_n = 1'b0;
        step(2);
        checks++; if ({key_level, press_pulse, release_pulse} !== 9'd0) begin
            errors++; $display("FAIL hold_reset: got %b/%b/%b want zeros", key_level, press_pulse, release_pulse);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            if (k == 5) begin
                checks++; if (key_level[0] !== 1'b0) begin errors++; $display("FAIL hold_early: got %b want 0", key_level[0]); end
            end
            if (k == 6) begin
                checks++; if (press_pulse !== 3'b001) begin errors++; $display("FAIL hold_press: got %b want 001", press_pulse); end
                checks++; if (key_level !== 3'b001) begin errors++; $display("FAIL hold_level: got %b want 001", key_level); end
            end
        end
        test_release(0);
    endtask

    initial begin
        rst_n = 1'b0; KEY = 3'b111; repeat_en = 1'b0;
        test_reset();
        test_clean_press();
        test_release(1);
        test_glitch();
        test_bounce();
        test_auto_repeat();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
